lnx_responder: RTL and testbench

Peripheral-side responder for the Lnx sequencing controller. The controller raises a level request in its two wait states and advances on `Ready`. It loops until `Flag` is seen in its test state. This block produces that `Ready`/`Flag` pair:
- it serves an operand read and a result write per iteration from a small local word buffer;
- it reports end of session after the last item's write.

---
 rtl/lnx_pkg.sv | 34 +++
 rtl/lnx_resp_if.sv | 40 ++++
 rtl/lnx_resp_buf.sv | 58 +++++
 rtl/lnx_responder.sv | 201 ++++++++++++++++++++
 tb/tb_lnx_responder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lnx_pkg.sv
// ----------------------------------------------------------------------------
// lnx_pkg
// Shared definitions for the Lnx responder slice: FSM state encoding, request
// kind constants, default geometry and a helper that clamps the session item
// count to the buffer depth.
// ----------------------------------------------------------------------------
package lnx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic KIND_RD = 1'b0;
  localparam logic KIND_WR = 1'b1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_LAT    = 2;

  // A session can never address more items than the buffer holds.
  function automatic logic [4:0] clamp_count(input logic [3:0] count,
                                             input logic [4:0] depth);
    logic [4:0] wide;
    wide = {1'b0, count};
    if (wide > depth) begin
      return depth;
    end else begin
      return wide;
    end
  endfunction

endpackage

// File: rtl/lnx_resp_if.sv
// ----------------------------------------------------------------------------
// lnx_resp_if
// Bundle of the controller/host facing signals of the Lnx responder.
//   master : controller + host side (drives Load/Count/Req/ReqKind/DataIn and
//            the host buffer port, observes DataOut/Ready/Flag/HostRdata)
//   slave  : responder side (mirror image)
// ----------------------------------------------------------------------------
interface lnx_resp_if
  import lnx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic              Load;
  logic [3:0]        Count;
  logic              Req;
  logic              ReqKind;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;
  logic              Ready;
  logic              Flag;
  logic              HostWe;
  logic [AW-1:0]     HostAddr;
  logic [DATA_W-1:0] HostWdata;
  logic [DATA_W-1:0] HostRdata;

  modport master (
    output Load, Count, Req, ReqKind, DataIn, HostWe, HostAddr, HostWdata,
    input  DataOut, Ready, Flag, HostRdata
  );

  modport slave (
    input  Load, Count, Req, ReqKind, DataIn, HostWe, HostAddr, HostWdata,
    output DataOut, Ready, Flag, HostRdata
  );

endinterface

// File: rtl/lnx_resp_buf.sv
// ----------------------------------------------------------------------------
// lnx_resp_buf
// Word buffer with two write ports (responder, host) and two combinational
// read ports. On a same-address collision the responder write lands and the
// host write is dropped; writes to different addresses both land.
// Ports:
//   clk_i                      : clock
//   resp_we_i/addr_i/wdata_i   : responder write port
//   resp_rdata_o               : combinational read at resp_addr_i
//   host_we_i/addr_i/wdata_i   : host write port
//   host_rdata_o               : combinational read at host_addr_i
// Contents are deliberately not reset.
// ----------------------------------------------------------------------------
module lnx_resp_buf
  import lnx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              resp_we_i,
  input  logic [AW-1:0]     resp_addr_i,
  input  logic [DATA_W-1:0] resp_wdata_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  input  logic              host_we_i,
  input  logic [AW-1:0]     host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic [DATA_W-1:0] host_rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              host_wr_s;

  // Host write is suppressed only when the responder targets the same word.
  always_comb begin
    host_wr_s = host_we_i;
    if (resp_we_i && (resp_addr_i == host_addr_i)) begin
      host_wr_s = 1'b0;
    end else begin
      host_wr_s = host_we_i;
    end
  end

  // Storage update from both write ports.
  always_ff @(posedge clk_i) begin
    if (host_wr_s) begin
      mem_q[host_addr_i] <= host_wdata_i;
    end
    if (resp_we_i) begin
      mem_q[resp_addr_i] <= resp_wdata_i;
    end
  end

  assign resp_rdata_o = mem_q[resp_addr_i];
  assign host_rdata_o = mem_q[host_addr_i];

endmodule

// File: rtl/lnx_responder.sv
// ----------------------------------------------------------------------------
// lnx_responder
// Peripheral-side responder for the Lnx sequencing controller. Each level
// request is answered with a one-cycle Ready strobe after a fixed latency;
// reads return buffer[Idx], writes store DataIn at buffer[Idx] and advance Idx.
// Flag reports that Idx has reached the session item count.
// Ports:
//   Clock : clock, rising edge
//   Reset : asynchronous, active-high
//   bus   : lnx_resp_if.slave (Load/Count, Req/ReqKind/DataIn, DataOut/Ready/
//           Flag, host buffer port HostWe/HostAddr/HostWdata/HostRdata)
// Configuration macro:
//   LNX_RESP_LATENCY_EN : defined -> LAT cycles from capture to Ready;
//                         undefined -> Ready one cycle after capture.
// ----------------------------------------------------------------------------
module lnx_responder
  import lnx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LAT    = DEF_LAT
) (
  input  logic        Clock,
  input  logic        Reset,
  lnx_resp_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;

  if (LAT < 1) begin : g_lat_chk
    $error("lnx_responder: LAT must be at least 1");
  end
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("lnx_responder: DEPTH must be a power of two in 2..16");
  end

  state_e            state_q, state_d;
  logic              kind_q, kind_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     sess_q, sess_d;
  logic              ready_q, ready_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              fire_s;
  logic              done_s;
  logic              buf_we_s;
  logic [DATA_W-1:0] buf_rd_s;
  logic [IW-1:0]     load_cnt_s;

`ifdef LNX_RESP_LATENCY_EN
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign load_cnt_s = IW'(clamp_count(bus.Count, 5'(DEPTH)));
  // Once every item has been written, further requests are answered but inert.
  assign done_s     = (idx_q == sess_q);

  // State, session and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_RD;
      idx_q   <= '0;
      sess_q  <= '0;
      ready_q <= 1'b0;
      flag_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      sess_q  <= sess_d;
      ready_q <= ready_d;
      flag_q  <= flag_d;
      dout_q  <= dout_d;
    end
  end

`ifdef LNX_RESP_LATENCY_EN
  // Latency counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next-state logic; fire_s marks the edge that produces Ready.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    fire_s  = 1'b0;
`ifdef LNX_RESP_LATENCY_EN
    cnt_d   = cnt_q;
`endif
    if (bus.Load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Req) begin
            state_d = ST_BUSY;
            kind_d  = bus.ReqKind;
`ifdef LNX_RESP_LATENCY_EN
            cnt_d   = CW'(LAT - 1);
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Dropping Req before the response aborts without side effects.
          if (!bus.Req) begin
            state_d = ST_IDLE;
`ifdef LNX_RESP_LATENCY_EN
          end else if (cnt_q == '0) begin
            fire_s  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            cnt_d   = cnt_q - CW'(1);
          end
`else
          end else begin
            fire_s  = 1'b1;
            state_d = ST_HOLD;
          end
`endif
        end
        ST_HOLD: begin
          // Wait for Req to fall so one request yields exactly one Ready.
          if (!bus.Req) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    ready_d  = fire_s;
    dout_d   = dout_q;
    idx_d    = idx_q;
    sess_d   = sess_q;
    flag_d   = done_s;
    buf_we_s = 1'b0;
    if (bus.Load) begin
      idx_d  = '0;
      sess_d = load_cnt_s;
      flag_d = (load_cnt_s == '0);
    end else if (fire_s) begin
      if (kind_q == KIND_RD) begin
        if (done_s) begin
          dout_d = '0;
        end else begin
          dout_d = buf_rd_s;
        end
      end else begin
        if (done_s) begin
          buf_we_s = 1'b0;
          idx_d    = idx_q;
        end else begin
          buf_we_s = 1'b1;
          idx_d    = idx_q + IW'(1);
        end
      end
    end else begin
      dout_d = dout_q;
    end
  end

  lnx_resp_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk_i        (Clock),
    .resp_we_i    (buf_we_s),
    .resp_addr_i  (idx_q[AW-1:0]),
    .resp_wdata_i (bus.DataIn),
    .resp_rdata_o (buf_rd_s),
    .host_we_i    (bus.HostWe),
    .host_addr_i  (bus.HostAddr),
    .host_wdata_i (bus.HostWdata),
    .host_rdata_o (bus.HostRdata)
  );

  assign bus.DataOut = dout_q;
  assign bus.Ready   = ready_q;
  assign bus.Flag    = flag_q;

endmodule

// File: tb/tb_lnx_responder.sv
// ----------------------------------------------------------------------------
// tb_lnx_responder
// Self-checking bench for lnx_responder: a vector table for the basic
// read/write session, hand-written sequences for abort, Load override, write
// collision, empty session and asynchronous reset, then random sessions
// checked against a transaction-level model of the buffer and index.
// ----------------------------------------------------------------------------
module tb_lnx_responder;
  import lnx_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int LAT    = 4;
  localparam int AW     = $clog2(DEPTH);
`ifdef LNX_RESP_LATENCY_EN
  localparam int EFF_LAT = LAT;
`else
  localparam int EFF_LAT = 1;
`endif

  logic Clock = 1'b0;
  logic Reset;

  lnx_resp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  lnx_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       kind;
    logic [7:0] wdata;
    logic [7:0] exp_dout;
    logic       exp_flag;
  } vec_t;

  vec_t vecs [8];

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: buffer image, item index, session length.
  logic [7:0] m_mem [DEPTH];
  int         m_idx;
  int         m_cnt;
  logic [7:0] m_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    bus.HostWe    = 1'b1;
    bus.HostAddr  = AW'(a);
    bus.HostWdata = d;
    tick();
    bus.HostWe    = 1'b0;
    m_mem[a]      = d;
  endtask

  task automatic host_check(input int a, input string name);
    bus.HostAddr = AW'(a);
    #1;
    check(name, 32'(bus.HostRdata), 32'(m_mem[a]));
  endtask

  task automatic check_all(input string name);
    tick();
    for (int a = 0; a < DEPTH; a++) host_check(a, name);
  endtask

  task automatic load(input int cnt);
    bus.Load  = 1'b1;
    bus.Count = 4'(cnt);
    tick();
    bus.Load  = 1'b0;
    m_cnt     = (cnt > DEPTH) ? DEPTH : cnt;
    m_idx     = 0;
    check("load_flag", 32'(bus.Flag), 32'(m_cnt == 0));
  endtask

  // One full request: raise Req, wait for Ready, hold one cycle, drop Req.
  task automatic run_txn(input logic kind, input logic [7:0] wd, input logic [7:0] exp_dout,
                         input logic flag_pre, input logic flag_post, input string tag);
    int n;
    bit seen;
    bus.ReqKind = kind;
    bus.DataIn  = wd;
    bus.Req     = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.Ready) seen = 1'b1;
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, n, EFF_LAT + 1);
    check({tag, "_dout"}, 32'(bus.DataOut), 32'(exp_dout));
    check({tag, "_flag_pre"}, 32'(bus.Flag), 32'(flag_pre));
    tick();
    check({tag, "_ready_single"}, 32'(bus.Ready), 32'd0);
    check({tag, "_flag_post"}, 32'(bus.Flag), 32'(flag_post));
    bus.Req = 1'b0;
    tick();
  endtask

  task automatic model_txn(input logic kind, input logic [7:0] wd, input string tag);
    logic [7:0] exp;
    logic pre;
    logic post;
    pre = (m_idx == m_cnt);
    if (kind == KIND_RD) begin
      exp    = pre ? 8'h00 : m_mem[m_idx];
      m_dout = exp;
    end else begin
      exp = m_dout;
      if (!pre) begin
        m_mem[m_idx] = wd;
        m_idx++;
      end
    end
    post = (m_idx == m_cnt);
    run_txn(kind, wd, exp, pre, post, tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_flag;
    int   n;

    vecs[0] = '{KIND_RD, 8'h00, 8'h11, 1'b0};
    vecs[1] = '{KIND_WR, 8'hA0, 8'h11, 1'b0};
    vecs[2] = '{KIND_RD, 8'h00, 8'h22, 1'b0};
    vecs[3] = '{KIND_WR, 8'hA1, 8'h22, 1'b0};
    vecs[4] = '{KIND_RD, 8'h00, 8'h33, 1'b0};
    vecs[5] = '{KIND_WR, 8'hA2, 8'h33, 1'b1};
    vecs[6] = '{KIND_RD, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{KIND_WR, 8'h5A, 8'h00, 1'b1};

    Reset         = 1'b1;
    bus.Load      = 1'b0;
    bus.Count     = 4'd0;
    bus.Req       = 1'b0;
    bus.ReqKind   = KIND_RD;
    bus.DataIn    = 8'h00;
    bus.HostWe    = 1'b0;
    bus.HostAddr  = '0;
    bus.HostWdata = 8'h00;
    m_idx  = 0;
    m_cnt  = 0;
    m_dout = 8'h00;

    #12 Reset = 1'b0;
    #1;
    check("rst_ready", 32'(bus.Ready), 32'd0);
    check("rst_flag", 32'(bus.Flag), 32'd0);
    check("rst_dout", 32'(bus.DataOut), 32'd0);

    // Basic session from the vector table.
    host_write(0, 8'h11); host_write(1, 8'h22); host_write(2, 8'h33); host_write(3, 8'h44);
    host_write(4, 8'h55); host_write(5, 8'h66); host_write(6, 8'h77); host_write(7, 8'h88);
    host_check(2, "host_rd_zero_lat");
    load(3);
    prev_flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].kind, vecs[i].wdata, vecs[i].exp_dout, prev_flag, vecs[i].exp_flag, "vec");
      prev_flag = vecs[i].exp_flag;
    end
    m_mem[0] = 8'hA0; m_mem[1] = 8'hA1; m_mem[2] = 8'hA2;
    m_idx = 3; m_dout = 8'h00;
    check_all("vec_buf");

    // Req dropped while BUSY: no Ready, nothing changes.
    load(2);
    bus.ReqKind = KIND_WR; bus.DataIn = 8'hEE; bus.Req = 1'b1;
    tick();
    if (EFF_LAT >= 2) tick();
    bus.Req = 1'b0;
    for (int i = 0; i < EFF_LAT + 2; i++) begin
      tick();
      check("abort_no_ready", 32'(bus.Ready), 32'd0);
    end
    model_txn(KIND_RD, 8'h00, "abort_rd");
    model_txn(KIND_WR, 8'h5B, "abort_wr");
    check_all("abort_buf");

    // Load just before the Ready edge cancels the pending write.
    bus.ReqKind = KIND_WR; bus.DataIn = 8'hCC; bus.Req = 1'b1;
    tick();
    repeat (EFF_LAT - 1) tick();
    bus.Load = 1'b1; bus.Count = 4'd1;
    tick();
    bus.Load = 1'b0; bus.Req = 1'b0;
    m_idx = 0; m_cnt = 1;
    check("ovr_no_ready", 32'(bus.Ready), 32'd0);
    check("ovr_flag", 32'(bus.Flag), 32'd0);
    tick();
    check("ovr_no_late_ready", 32'(bus.Ready), 32'd0);
    check_all("ovr_buf");

    // Host and responder write the same word on the same edge.
    bus.ReqKind = KIND_WR; bus.DataIn = 8'hA0; bus.Req = 1'b1;
    tick();
    repeat (EFF_LAT - 1) tick();
    bus.HostWe = 1'b1; bus.HostAddr = AW'(0); bus.HostWdata = 8'h55;
    tick();
    bus.HostWe = 1'b0;
    check("coll_ready", 32'(bus.Ready), 32'd1);
    m_mem[0] = 8'hA0; m_idx = 1;
    host_check(0, "coll_buf");
    tick();
    check("coll_flag", 32'(bus.Flag), 32'd1);
    bus.Req = 1'b0;
    tick();

    // Empty session: Flag immediately, read answered with zero.
    load(0);
    model_txn(KIND_RD, 8'h00, "empty_rd");

    // Asynchronous reset between edges while BUSY.
    load(1);
    model_txn(KIND_RD, 8'h00, "pre_rst_rd");
    model_txn(KIND_WR, 8'h77, "pre_rst_wr");
    bus.ReqKind = KIND_RD; bus.Req = 1'b1;
    tick();
    #2 Reset = 1'b1;
    #1;
    check("arst_ready", 32'(bus.Ready), 32'd0);
    check("arst_flag", 32'(bus.Flag), 32'd0);
    check("arst_dout", 32'(bus.DataOut), 32'd0);
    bus.Req = 1'b0;
    @(posedge Clock);
    #3 Reset = 1'b0;
    m_idx = 0; m_cnt = 0; m_dout = 8'h00;
    tick();
    tick();
    model_txn(KIND_RD, 8'h00, "post_rst_rd");

    // Random sessions against the model, including counts beyond DEPTH.
    for (int s = 0; s < 25; s++) begin
      host_write($urandom_range(0, DEPTH - 1), 8'($urandom));
      host_write($urandom_range(0, DEPTH - 1), 8'($urandom));
      load($urandom_range(0, 15));
      n = $urandom_range(0, 2 * m_cnt + 3);
      for (int t = 0; t < n; t++) begin
        model_txn(1'($urandom_range(0, 1)), 8'($urandom), "rnd");
      end
      check_all("rnd_buf");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
